// File: rtl/ro_mem_responder_pkg.sv
// Shared types and default geometry for the read-only memory responder.
// The FSM is one-hot: each state owns a single bit of the encoding.
package ro_mem_responder_pkg;

  localparam int unsigned RESP_IDLE_IDX   = 0;
  localparam int unsigned RESP_ISSUE_IDX  = 1;
  localparam int unsigned RESP_NUM_STATES = 2;

  localparam int unsigned DEF_ADDR_W       = 30;
  localparam int unsigned DEF_DATA_W       = 32;
  localparam int unsigned DEF_RLEN_W       = 5;
  localparam int unsigned DEF_READ_LATENCY = 2;

  typedef enum logic [RESP_NUM_STATES-1:0] {
    RESP_IDLE  = 2'b01,
    RESP_ISSUE = 2'b10
  } ro_mem_responder_state_t;

endpackage

// File: rtl/ro_mem_responder_if.sv
// Master <-> responder read-only request bus: request/addr/rlen -> ack,
// then rlen+1 in-order rvalid/rdata beats with no backpressure.
interface ro_mem_responder_if
  import ro_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned RLEN_W = DEF_RLEN_W
);

  logic              request;
  logic [ADDR_W-1:0] addr;
  logic [RLEN_W-1:0] rlen;
  logic              ack;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output request,
    output addr,
    output rlen,
    input  ack,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  request,
    input  addr,
    input  rlen,
    output ack,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/ro_mem_responder_latency_shift.sv
// 1-bit shift register that delays a strobe by DEPTH cycles.
// Used to mark which cycles carry valid data on a fixed-latency port.
// clr_n is a synchronous active-low clear that drops everything in flight.
module latency_shift
  import ro_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_READ_LATENCY
) (
  input  logic clk,
  input  logic clr_n,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  if (DEPTH == 1) begin : g_single
    // Single stage: the next value is simply the incoming strobe.
    always_comb begin
      sr_d = din;
    end
  end else begin : g_multi
    // Shift the strobe one stage deeper each cycle.
    always_comb begin
      sr_d = {sr_q[DEPTH-2:0], din};
    end
  end

  // Stage register with synchronous clear.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      sr_q <= {DEPTH{1'b0}};
    end else begin
      sr_q <= sr_d;
    end
  end

  assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/ro_mem_responder.sv
// Responder end of the read-only memory protocol. Accepts one burst request
// at a time, streams rlen+1 consecutive word reads into a fixed-latency
// backend, and returns the data in order as registered rvalid/rdata beats.
// A new request can be acked on the last issue beat of the current burst,
// so back-to-back bursts issue without a bubble.
module ro_mem_responder
  import ro_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned RLEN_W       = DEF_RLEN_W,
  parameter int unsigned READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic                 clk,
  input  logic                 rst,
  ro_mem_responder_if.slave    bus,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_rd_addr,
  input  logic                 mem_rd_ready,
  input  logic [DATA_W-1:0]    mem_rd_data
);

  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [RLEN_W-1:0] BEATS_ONE = {{(RLEN_W-1){1'b0}}, 1'b1};

  ro_mem_responder_state_t state_q;
  ro_mem_responder_state_t state_d;
  logic [ADDR_W-1:0]       cur_addr_q;
  logic [ADDR_W-1:0]       cur_addr_d;
  logic [RLEN_W-1:0]       beats_left_q;
  logic [RLEN_W-1:0]       beats_left_d;
  logic                    rvalid_q;
  logic                    rvalid_d;
  logic [DATA_W-1:0]       rdata_q;
  logic [DATA_W-1:0]       rdata_d;

  logic in_idle_s;
  logic in_issue_s;
  logic last_beat_s;
  logic issue_fire_s;
  logic ack_s;
  logic pipe_tail_s;

  // Decode state and derive the acceptance / issue strobes.
  always_comb begin
    in_idle_s    = (state_q == RESP_IDLE);
    in_issue_s   = (state_q == RESP_ISSUE);
    last_beat_s  = (beats_left_q == {RLEN_W{1'b0}});
    issue_fire_s = rst & in_issue_s & mem_rd_ready;
    // In IDLE the ack does not wait for the backend; in ISSUE it only
    // fires when the final beat of the current burst is being accepted.
    ack_s        = rst & bus.request &
                   (in_idle_s | (in_issue_s & last_beat_s & mem_rd_ready));
  end

  // Next-state, address and beat-counter logic.
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    case (state_q)
      RESP_IDLE: begin
        if (ack_s) begin
          cur_addr_d   = bus.addr;
          beats_left_d = bus.rlen;
          state_d      = RESP_ISSUE;
        end else begin
          state_d      = RESP_IDLE;
        end
      end
      RESP_ISSUE: begin
        if (mem_rd_ready) begin
          if (last_beat_s) begin
            if (ack_s) begin
              // Reload for the next burst; the issue stream stays contiguous.
              cur_addr_d   = bus.addr;
              beats_left_d = bus.rlen;
              state_d      = RESP_ISSUE;
            end else begin
              cur_addr_d   = cur_addr_q + ADDR_ONE;
              state_d      = RESP_IDLE;
            end
          end else begin
            // Word address wraps naturally at 2^ADDR_W.
            cur_addr_d   = cur_addr_q + ADDR_ONE;
            beats_left_d = beats_left_q - BEATS_ONE;
            state_d      = RESP_ISSUE;
          end
        end else begin
          // Backend stalled: hold the issued address and count.
          state_d = RESP_ISSUE;
        end
      end
      default: begin
        state_d      = RESP_IDLE;
        cur_addr_d   = {ADDR_W{1'b0}};
        beats_left_d = {RLEN_W{1'b0}};
      end
    endcase
  end

  // Tracks which cycles the backend presents data for an accepted strobe.
  latency_shift #(
    .DEPTH (READ_LATENCY)
  ) u_valid_pipe (
    .clk   (clk),
    .clr_n (rst),
    .din   (issue_fire_s),
    .dout  (pipe_tail_s)
  );

  // Capture backend data at the pipe tail; otherwise hold the last word.
  always_comb begin
    if (pipe_tail_s) begin
      rvalid_d = 1'b1;
      rdata_d  = mem_rd_data;
    end else begin
      rvalid_d = 1'b0;
      rdata_d  = rdata_q;
    end
  end

  // State, counters and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= RESP_IDLE;
      cur_addr_q   <= {ADDR_W{1'b0}};
      beats_left_q <= {RLEN_W{1'b0}};
      rvalid_q     <= 1'b0;
      rdata_q      <= {DATA_W{1'b0}};
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
    end
  end

  // The strobe is masked by reset so nothing is issued while it is held.
  assign mem_rd_en   = rst & in_issue_s;
  assign mem_rd_addr = cur_addr_q;

  assign bus.ack    = ack_s;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_ro_mem_responder.sv
// Scoreboard bench for ro_mem_responder. A predictor turns observed
// requests into an ordered list of word addresses still to be read and,
// once each word is accepted by the backend, into an expected
// (cycle, data) beat; a separate monitor pops and compares beats.
module tb_ro_mem_responder;
  import ro_mem_responder_pkg::*;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int RLEN_W = 5;
  localparam int LAT    = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rd_ready = 1'b1;
  logic [DATA_W-1:0] mem_rd_data  = 32'h0;

  ro_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RLEN_W(RLEN_W)) bus ();

  ro_mem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RLEN_W(RLEN_W), .READ_LATENCY(LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_ready (mem_rd_ready),
    .mem_rd_data  (mem_rd_data)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  int                exp_t[$];
  logic [DATA_W-1:0] exp_d[$];
  logic [ADDR_W-1:0] iss_q[$];

  logic [DATA_W-1:0] ovr [logic [ADDR_W-1:0]];
  logic              acc_v [8];
  logic [ADDR_W-1:0] acc_a [8];

  int                ready_mode   = 0;
  int                rv_count     = 0;
  int                last_rv_cyc  = -1;
  logic [DATA_W-1:0] last_rv_data = 32'h0;
  logic [DATA_W-1:0] hold_d       = 32'h0;

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    if (ovr.exists(a)) return ovr[a];
    return {a, 2'b01} ^ (32'h9E37_79B9 * {2'b00, a});
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Backend: records accepted strobes, returns their word LAT cycles later.
  initial begin
    for (int i = 0; i < 8; i++) begin
      acc_v[i] = 1'b0;
      acc_a[i] = 30'h0;
    end
    forever begin
      @(posedge clk);
      #1;
      if (cyc >= LAT && acc_v[(cyc - LAT) % 8]) mem_rd_data = mem_word(acc_a[(cyc - LAT) % 8]);
      else mem_rd_data = $urandom;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      acc_v[cyc % 8] = (mem_rd_en === 1'b1) && mem_rd_ready;
      acc_a[cyc % 8] = mem_rd_addr;
    end
  end

  // Predictor: models ack/issue from the list of words still owed.
  initial begin : predictor
    logic              busy;
    logic              e_ack;
    logic [ADDR_W-1:0] a;
    @(posedge clk);
    forever begin
      @(negedge clk);
      #1;
      if (rst === 1'b0) begin
        chk("ack_in_reset", bus.ack, 1'b0);
        chk("rd_en_in_reset", mem_rd_en, 1'b0);
        exp_t.delete();
        exp_d.delete();
        iss_q.delete();
      end else begin
        busy  = (iss_q.size() != 0);
        e_ack = bus.request && (!busy || (iss_q.size() == 1 && mem_rd_ready));
        chk("ack", bus.ack, e_ack);
        chk("mem_rd_en", mem_rd_en, busy);
        if (busy) chk("mem_rd_addr", mem_rd_addr, iss_q[0]);
        if (busy && mem_rd_ready) begin
          a = iss_q.pop_front();
          exp_t.push_back(cyc + LAT + 1);
          exp_d.push_back(mem_word(a));
        end
        if (e_ack) begin
          for (int i = 0; i <= int'(bus.rlen); i++) iss_q.push_back(bus.addr + 30'(i));
        end
      end
    end
  end

  // Monitor: every cycle either the next expected beat or a quiet bus.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (bus.rvalid === 1'b1) rv_count++;
      if (exp_t.size() > 0 && exp_t[0] == cyc) begin
        chk("rvalid", bus.rvalid, 1'b1);
        chk("rdata", bus.rdata, exp_d[0]);
        hold_d       = exp_d[0];
        last_rv_cyc  = cyc;
        last_rv_data = bus.rdata;
        void'(exp_t.pop_front());
        void'(exp_d.pop_front());
      end else begin
        chk("rvalid_idle", bus.rvalid, 1'b0);
        chk("rdata_hold", bus.rdata, hold_d);
      end
      if (rst === 1'b0) hold_d = 32'h0;
    end
  end

  task automatic drive_ready();
    if (ready_mode == 0) mem_rd_ready = 1'b1;
    else mem_rd_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive_ready();
  endtask

  task automatic idle(input int n);
    bus.request = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(input logic [ADDR_W-1:0] a, input logic [RLEN_W-1:0] l,
                      input int hold, output int acy);
    bit got = 0;
    int n   = 0;
    acy         = -1;
    bus.request = 1'b1;
    bus.addr    = a;
    bus.rlen    = l;
    while (!got && n < 300) begin
      @(negedge clk);
      #2;
      if (bus.ack === 1'b1) begin
        got = 1;
        acy = cyc;
      end
      n++;
      step();
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL ack_timeout: got no ack expected ack within 300 cycles (addr %0h)", a);
    end
    if (hold > 0) repeat (hold) step();
    bus.request = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bus.request = 1'b0;
    while ((exp_t.size() != 0 || iss_q.size() != 0) && n < 1000) begin
      step();
      n++;
    end
    if (n >= 1000) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_t.size() + iss_q.size());
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int t1;
    int t2;
    int rv0;
    logic [ADDR_W-1:0] ra;
    logic [RLEN_W-1:0] rl;
    bus.request = 1'b1;
    bus.addr    = 30'h15;
    bus.rlen    = 5'd0;

    // Reset held with a pending request: nothing may be acked or issued.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.request = 1'b0;
    idle(2);

    // Single read with fixed data.
    ovr[30'h0001234] = 32'hDEAD_BEEF;
    send(30'h0001234, 5'd0, 0, t1);
    drain();
    idle(2);
    chk("single_latency", last_rv_cyc, t1 + 4);
    chk("single_data", last_rv_data, 32'hDEAD_BEEF);

    // Burst across the address wrap, backend stalls on the second issue.
    rv0 = rv_count;
    send(30'h3FFF_FFFE, 5'd3, 0, t1);
    @(posedge clk); #1; mem_rd_ready = 1'b0;
    @(posedge clk); #1; mem_rd_ready = 1'b0;
    @(posedge clk); #1; mem_rd_ready = 1'b1;
    drain();
    idle(2);
    chk("wrap_beats", rv_count - rv0, 4);

    // Back-to-back bursts: second ack lands on the first burst's last issue.
    rv0 = rv_count;
    send(30'h0000_0100, 5'd1, 0, t1);
    send(30'h0000_0200, 5'd1, 0, t2);
    chk("b2b_ack_gap", t2 - t1, 2);
    drain();
    idle(2);
    chk("b2b_beats", rv_count - rv0, 4);

    // Master abort: request lingers a cycle, then drops.
    rv0 = rv_count;
    send(30'h0000_0300, 5'd2, 1, t1);
    drain();
    idle(2);
    chk("abort_beats", rv_count - rv0, 3);

    // Reset after three issues of an eight-beat burst.
    send(30'h0000_0400, 5'd7, 0, t1);
    step();
    step();
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b1;
    rv0 = rv_count;
    idle(12);
    chk("reset_flush_beats", rv_count - rv0, 0);
    rv0 = rv_count;
    send(30'h0000_0500, 5'd0, 0, t1);
    drain();
    idle(2);
    chk("post_reset_beats", rv_count - rv0, 1);

    // Randomized traffic with backend stalls, wraps and occasional resets.
    ready_mode = 1;
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 3) == 0) ra = 30'h3FFF_FFF0 + 30'($urandom_range(0, 15));
      else ra = 30'($urandom);
      if ($urandom_range(0, 7) == 0) rl = 5'd31;
      else rl = 5'($urandom_range(0, 3));
      send(ra, rl, $urandom_range(0, 1), t1);
      if ($urandom_range(0, 19) == 0) begin
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
      end
      idle($urandom_range(0, 3));
    end
    ready_mode = 0;
    drain();
    idle(4);
    chk("final_issue_queue", iss_q.size(), 0);
    chk("final_beat_queue", exp_t.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
